lcd_tile_sink: RTL

- Downstream consumer of the image display controller's output stream.
- Captures each 16-pixel (4x4) output burst, signalled by `output_valid`, into a ping-pong tile buffer.
- Replays each captured tile to the panel driver over a valid/ready handshake, tagging every pixel with row, column and an end-of-tile marker.
- Decouples the controller's fixed-rate burst from a panel that may stall.

---
 rtl/lcd_tile_pkg.sv | 33 +++
 rtl/lcd_tile_bank.sv | 34 +++
 rtl/lcd_tile_sink.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_tile_pkg.sv
// Shared types and helpers for the LCD tile sink.
// Tile geometry, FSM state encodings and index decode.
package lcd_tile_pkg;

    localparam int TILE_PIX = 16;
    localparam int TILE_W   = 4;

    localparam logic [TILE_W-1:0] LAST_IDX = TILE_W'(TILE_PIX - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_SEND
    } rd_state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rowcol_t;

    function automatic rowcol_t idx2rowcol(input logic [TILE_W-1:0] idx);
        rowcol_t rc;
        rc.row = idx[3:2];
        rc.col = idx[1:0];
        return rc;
    endfunction

endpackage

// File: rtl/lcd_tile_bank.sv
// Ping-pong tile storage: 2 banks x 16 pixels, one write and one read port.
// Contents are not reset; bank validity is tracked by the top level.
module lcd_tile_bank
    import lcd_tile_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              w_bank,
    input  logic [TILE_W-1:0] w_idx,
    input  logic [DW-1:0]     w_data,
    input  logic              r_bank,
    input  logic [TILE_W-1:0] r_idx,
    output logic [DW-1:0]     r_data
);

    logic [DW-1:0] mem_q [2][TILE_PIX];
    logic [DW-1:0] mem_d [2][TILE_PIX];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[w_bank][w_idx] = w_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign r_data = mem_q[r_bank][r_idx];

endmodule

// File: rtl/lcd_tile_sink.sv
// Captures 4x4 pixel bursts into a ping-pong buffer and replays them over valid/ready.
// Optional per-tile XOR checksum output enabled by LCD_TILE_SINK_CKSUM_EN.
module lcd_tile_sink
    import lcd_tile_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    pix_in,
    input  logic             pix_valid,
    output logic [DW-1:0]    px_data,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [1:0]       px_row,
    output logic [1:0]       px_col,
    output logic             px_last,
    input  logic             clr_flags,
    output logic             ovf_flag,
    output logic             short_flag,
    output logic [CNT_W-1:0] tile_cnt
`ifdef LCD_TILE_SINK_CKSUM_EN
    ,
    output logic [DW-1:0]    px_cksum
`endif
);

    wr_state_e         w_st_q, w_st_d;
    logic              wr_bank_q, wr_bank_d;
    logic [TILE_W-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]        full_q, full_d;
    rd_state_e         r_st_q, r_st_d;
    logic              rd_bank_q, rd_bank_d;
    logic [TILE_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              short_q, short_d;

    logic              we;
    logic [TILE_W-1:0] w_idx;
    logic              rel;
    logic              done;
    logic              bank_free;
    logic              ovf_set;
    logic              short_set;
    logic [DW-1:0]     rdata;
    rowcol_t           rc;

    lcd_tile_bank #(
        .DW(DW)
    ) u_bank (
        .clk   (clk),
        .we    (we),
        .w_bank(wr_bank_q),
        .w_idx (w_idx),
        .w_data(pix_in),
        .r_bank(rd_bank_q),
        .r_idx (rd_idx_q),
        .r_data(rdata)
    );

    always_comb begin
        r_st_d    = r_st_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        cnt_d     = cnt_q;
        rel       = 1'b0;
        unique case (r_st_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    r_st_d   = R_SEND;
                    rd_idx_d = '0;
                end
            end
            R_SEND: begin
                if (px_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rel       = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_idx_d  = '0;
                        cnt_d     = cnt_q + CNT_W'(1);
                        // Next bank already waiting: keep streaming without a gap.
                        if (!full_q[~rd_bank_q]) begin
                            r_st_d = R_IDLE;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + TILE_W'(1);
                    end
                end
            end
            default: r_st_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_st_d    = w_st_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        full_d    = full_q;
        we        = 1'b0;
        w_idx     = wr_idx_q;
        ovf_set   = 1'b0;
        short_set = 1'b0;
        done      = 1'b0;
        if (rel) begin
            full_d[rd_bank_q] = 1'b0;
        end
        bank_free = !full_q[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q));
        unique case (w_st_q)
            W_IDLE: begin
                if (pix_valid) begin
                    if (bank_free) begin
                        we       = 1'b1;
                        w_idx    = '0;
                        wr_idx_d = TILE_W'(1);
                        w_st_d   = W_FILL;
                    end else begin
                        ovf_set = 1'b1;
                        w_st_d  = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (pix_valid) begin
                    we = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        done              = 1'b1;
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        wr_idx_d          = '0;
                        w_st_d            = W_IDLE;
                    end else begin
                        wr_idx_d = wr_idx_q + TILE_W'(1);
                    end
                end else begin
                    short_set = 1'b1;
                    wr_idx_d  = '0;
                    w_st_d    = W_IDLE;
                end
            end
            W_DROP: begin
                if (!pix_valid) begin
                    w_st_d = W_IDLE;
                end
            end
            default: w_st_d = W_IDLE;
        endcase
    end

    always_comb begin
        ovf_d   = (ovf_q & ~clr_flags) | ovf_set;
        short_d = (short_q & ~clr_flags) | short_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_st_q    <= W_IDLE;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= '0;
            r_st_q    <= R_IDLE;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            w_st_q    <= w_st_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            full_q    <= full_d;
            r_st_q    <= r_st_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            short_q   <= short_d;
        end
    end

    assign rc         = idx2rowcol(rd_idx_q);
    assign px_valid   = (r_st_q == R_SEND);
    assign px_data    = px_valid ? rdata : '0;
    assign px_row     = px_valid ? rc.row : 2'b00;
    assign px_col     = px_valid ? rc.col : 2'b00;
    assign px_last    = px_valid && (rd_idx_q == LAST_IDX);
    assign ovf_flag   = ovf_q;
    assign short_flag = short_q;
    assign tile_cnt   = cnt_q;

`ifdef LCD_TILE_SINK_CKSUM_EN
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] cks_q [2];
    logic [DW-1:0] cks_d [2];

    // Only a completed tile commits its checksum, so aborted bursts leave banks untouched.
    always_comb begin
        acc_d = acc_q;
        cks_d = cks_q;
        if (we) begin
            acc_d = (w_st_q == W_IDLE) ? pix_in : (acc_q ^ pix_in);
        end
        if (done) begin
            cks_d[wr_bank_q] = acc_q ^ pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            cks_q[0] <= '0;
            cks_q[1] <= '0;
        end else begin
            acc_q <= acc_d;
            cks_q <= cks_d;
        end
    end

    assign px_cksum = px_last ? cks_q[rd_bank_q] : '0;
`else
    logic unused_done;
    assign unused_done = done;
`endif

endmodule
